// File: rtl/mand_iterator.sv
// Escape-time Mandelbrot iterator: iterates z <- z^2 + c in signed 4.23 fixed point.
// Define MAND_ITERATOR_CARDIOID_EN to add a CHECK state for cardioid/period-2 bulb early-out.
module mand_iterator #(
   parameter int max_iterations = 1000,
   parameter int frac_bits      = 23
) (
   input  logic               clock,
   input  logic               reset,
   input  logic signed [26:0] c_re,
   input  logic signed [26:0] c_im,
   output logic               out_ready,
   output logic signed [31:0] out
);

   typedef enum logic [1:0] {LOAD, CHECK, ITER, DONE} state_t;

   localparam logic signed [55:0] four    = 56'sd4 <<< frac_bits;
   localparam logic signed [55:0] sat_max = 56'sd67108863;
   localparam logic signed [55:0] sat_min = -56'sd67108864;

   state_t             state;
   logic signed [26:0] c_re_r, c_im_r;
   logic signed [26:0] z_re, z_im;
   logic        [31:0] count;

   logic signed [55:0] p_rr, p_ii, p_ri;
   logic signed [55:0] s_rr, s_ii, s_ri;
   logic signed [55:0] mag, n_re, n_im;
   logic               escape;

   function automatic logic signed [26:0] sat27(input logic signed [55:0] v);
      if (v > sat_max)
         return sat_max[26:0];
      else if (v < sat_min)
         return sat_min[26:0];
      else
         return v[26:0];
   endfunction

   // Sums are carried wide; after a non-escape they are bounded well inside 29 bits.
   always_comb begin
      p_rr   = z_re * z_re;
      p_ii   = z_im * z_im;
      p_ri   = z_re * z_im;
      s_rr   = p_rr >>> frac_bits;
      s_ii   = p_ii >>> frac_bits;
      s_ri   = p_ri >>> frac_bits;
      mag    = s_rr + s_ii;
      escape = (mag > four);
      n_re   = s_rr - s_ii + c_re_r;
      n_im   = (s_ri <<< 1) + c_im_r;
   end

`ifdef MAND_ITERATOR_CARDIOID_EN
   localparam logic signed [55:0] quarter   = 56'sd1 <<< (frac_bits - 2);
   localparam logic signed [55:0] one       = 56'sd1 <<< frac_bits;
   localparam logic signed [55:0] sixteenth = 56'sd1 <<< (frac_bits - 4);

   logic signed [55:0]  xm, xp, y2p, y2, xm2, xp2, q;
   logic signed [111:0] pm, pp, pq, lhs;
   logic                card_hit, bulb_hit;

   always_comb begin
      xm       = c_re_r - quarter;
      xp       = c_re_r + one;
      y2p      = c_im_r * c_im_r;
      y2       = y2p >>> frac_bits;
      pm       = xm * xm;
      pp       = xp * xp;
      xm2      = 56'(pm >>> frac_bits);
      xp2      = 56'(pp >>> frac_bits);
      q        = xm2 + y2;
      pq       = q * (q + xm);
      lhs      = pq >>> frac_bits;
      card_hit = (lhs <= 112'(y2 >>> 2));
      bulb_hit = ((xp2 + y2) <= sixteenth);
   end
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= LOAD;
         c_re_r    <= '0;
         c_im_r    <= '0;
         z_re      <= '0;
         z_im      <= '0;
         count     <= '0;
         out       <= '0;
         out_ready <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               c_re_r <= c_re;
               c_im_r <= c_im;
               z_re   <= '0;
               z_im   <= '0;
               count  <= '0;
`ifdef MAND_ITERATOR_CARDIOID_EN
               state  <= CHECK;
`else
               state  <= ITER;
`endif
            end
`ifdef MAND_ITERATOR_CARDIOID_EN
            CHECK: begin
               if (card_hit || bulb_hit) begin
                  out       <= -32'sd1;
                  out_ready <= 1'b1;
                  state     <= DONE;
               end else begin
                  state <= ITER;
               end
            end
`endif
            ITER: begin
               if (escape) begin
                  out       <= $signed(count);
                  out_ready <= 1'b1;
                  state     <= DONE;
               end else if (count == 32'(max_iterations)) begin
                  out       <= -32'sd1;
                  out_ready <= 1'b1;
                  state     <= DONE;
               end else begin
                  z_re  <= sat27(n_re);
                  z_im  <= sat27(n_im);
                  count <= count + 32'd1;
               end
            end
            DONE:    state <= DONE;
            default: state <= LOAD;
         endcase
      end
   end

endmodule
